// File: rtl/weight_sequencer.sv
// rtl/weight_sequencer.sv - sequences buffered bytes through an external Hamming-weight counter
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   in_valid/in_data      upstream byte offer; in_ready high while the 4-entry FIFO has room
//   cnt_load/cnt_load_data load strobe and byte for the downstream counter
//   cnt_enable            counter run enable
//   cnt_count/cnt_done    counter result and level done flag
//   out_valid/out_ready   result handshake; out_byte/out_weight hold the result
//   clr                   synchronous clear of total
//   total                 running sum of captured weights (wraps at 4096)
//   busy                  high whenever the sequencer is not idle
module weight_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cnt_load,
  output logic [7:0]  cnt_load_data,
  output logic        cnt_enable,
  input  logic [3:0]  cnt_count,
  input  logic        cnt_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic [3:0]  out_weight,
  input  logic        clr,
  output logic [11:0] total,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, RELEASE} state_t;

  state_t     state;
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] occ;
  logic [7:0] byte_reg;

  logic       push;
  logic       pop;
  logic       not_empty;
  logic       slot_free;
  logic       capture;
  logic [7:0] head;

  assign in_ready  = ~occ[2];
  assign push      = in_valid & in_ready;
  assign pop       = (state == LOAD);
  assign not_empty = (occ != 3'd0);
  assign head      = fifo_mem[rd_ptr];
  // The output register can take new data if empty or being drained this cycle.
  assign slot_free = ~out_valid | out_ready;
  assign capture   = ((state == RUN) & cnt_done & slot_free) | ((state == HOLD) & slot_free);

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Counter-facing outputs are registered with the state, so each transition
  // also sets the strobes the destination state presents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt_load      <= 1'b0;
      cnt_load_data <= 8'h00;
      cnt_enable    <= 1'b0;
      busy          <= 1'b0;
      byte_reg      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (not_empty) begin
            state         <= LOAD;
            cnt_load      <= 1'b1;
            cnt_load_data <= head;
            busy          <= 1'b1;
          end
        end
        LOAD: begin
          byte_reg      <= head;
          state         <= RUN;
          cnt_load      <= 1'b0;
          cnt_load_data <= 8'h00;
          cnt_enable    <= 1'b1;
        end
        RUN: begin
          if (cnt_done) begin
            cnt_enable <= 1'b0;
            if (slot_free) begin
              state    <= RELEASE;
              cnt_load <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            state    <= RELEASE;
            cnt_load <= 1'b1;
          end
        end
        RELEASE: begin
          // Loading 8'h00 clears the counter's done flag before the next byte.
          if (not_empty) begin
            state         <= LOAD;
            cnt_load      <= 1'b1;
            cnt_load_data <= head;
          end else begin
            state    <= IDLE;
            cnt_load <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          cnt_load      <= 1'b0;
          cnt_load_data <= 8'h00;
          cnt_enable    <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_byte   <= 8'h00;
      out_weight <= 4'h0;
      total      <= 12'h000;
    end else begin
      if (capture) begin
        out_valid  <= 1'b1;
        out_byte   <= byte_reg;
        out_weight <= cnt_count;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A clear coinciding with a capture keeps that capture's weight.
      if (clr)
        total <= capture ? {8'h00, cnt_count} : 12'h000;
      else if (capture)
        total <= total + {8'h00, cnt_count};
    end
  end

endmodule

// File: tb/tb_weight_sequencer.sv
// tb/tb_weight_sequencer.sv - scoreboard bench for weight_sequencer with a behavioural counter
module tb_weight_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        cnt_load;
  logic [7:0]  cnt_load_data;
  logic        cnt_enable;
  logic [3:0]  cnt_count;
  logic        cnt_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic [3:0]  out_weight;
  logic        clr = 1'b0;
  logic [11:0] total;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [11:0] sb [$];
  logic [11:0] exp_total = 12'h000;

  weight_sequencer dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cnt_load(cnt_load), .cnt_load_data(cnt_load_data), .cnt_enable(cnt_enable),
    .cnt_count(cnt_count), .cnt_done(cnt_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_weight(out_weight), .clr(clr), .total(total), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter model: shifts one bit per enabled cycle, then settles two cycles before done.
  logic [7:0] m_reg;
  logic [3:0] m_cnt;
  logic [1:0] m_wait;
  assign cnt_count = m_cnt;
  assign cnt_done  = (m_reg == 8'h00) && (m_wait == 2'd2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= 8'h00; m_cnt <= 4'h0; m_wait <= 2'd0;
    end else if (cnt_load) begin
      m_reg <= cnt_load_data; m_cnt <= 4'h0; m_wait <= 2'd0;
    end else if (cnt_enable) begin
      if (m_reg != 8'h00) begin
        m_cnt <= m_cnt + {3'b000, m_reg[0]};
        m_reg <= m_reg >> 1;
      end else if (m_wait != 2'd2) begin
        m_wait <= m_wait + 2'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("orphan_valid", {31'b0, sb.size() == 0}, 0);
      if (out_ready && sb.size() > 0) begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("out_byte", {24'b0, out_byte}, {24'b0, e[11:4]});
        chk("out_weight", {28'b0, out_weight}, {28'b0, e[3:0]});
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    logic [3:0] w;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    chk("push_accept", {31'b0, in_ready}, 1);
    w = 4'($countones(b));
    sb.push_back({b, w});
    exp_total = exp_total + {8'h00, w};
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    chk("drain", {31'b0, done}, 1);
  endtask

  task automatic latency_test(input logic [7:0] b, input int exp_lat);
    int n = 0;
    int lat = 0;
    push_byte(b);
    @(negedge clk);
    while (!cnt_load && n < 50) begin n++; @(negedge clk); end
    chk("load_data", {24'b0, cnt_load_data}, {24'b0, b});
    @(negedge clk); lat = 1;
    while (!out_valid && lat < 50) begin lat++; @(negedge clk); end
    chk("latency", lat, exp_lat);
    wait_drain();
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_cnt_load", {31'b0, cnt_load}, 0);
    chk("rst_cnt_data", {24'b0, cnt_load_data}, 0);
    chk("rst_cnt_enable", {31'b0, cnt_enable}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_byte", {24'b0, out_byte}, 0);
    chk("rst_out_weight", {28'b0, out_weight}, 0);
    chk("rst_total", {20'b0, total}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_total = 12'h000;
    chk("clr_total", {20'b0, total}, 0);
  endtask

  initial begin
    int gaps;
    int n;
    #12;
    check_reset_vals();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Single byte with latency check.
    latency_test(8'hA5, 12);
    chk("a5_total", {20'b0, total}, {20'b0, exp_total});
    chk("a5_idle", {31'b0, busy}, 0);
    do_clr();

    // Back-to-back bytes must chain RELEASE->LOAD without going idle.
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h80);
    gaps = 0;
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() > 0) gaps++;
    end
    wait_drain();
    chk("b2b_gaps", gaps, 0);
    chk("b2b_total", {20'b0, total}, 9);

    latency_test(8'h00, 4);
    latency_test(8'h80, 12);

    // Backpressure: park in HOLD with the FIFO full after five quick pushes.
    out_ready = 1'b0;
    push_byte(8'h33); push_byte(8'hC3); push_byte(8'hF0); push_byte(8'h01); push_byte(8'h7E);
    chk("full_in_ready", {31'b0, in_ready}, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("hold_valid", {31'b0, out_valid}, 1);
    chk("hold_enable", {31'b0, cnt_enable}, 0);
    chk("hold_load", {31'b0, cnt_load}, 0);
    chk("hold_busy", {31'b0, busy}, 1);
    chk("hold_byte", {24'b0, out_byte}, 32'h33);
    out_ready = 1'b1;
    wait_drain();
    chk("hold_total", {20'b0, total}, {20'b0, exp_total});

    // Wrap of the running total.
    do_clr();
    for (int i = 0; i < 511; i++) push_byte(8'hFF);
    wait_drain();
    chk("total_4088", {20'b0, total}, 4088);
    push_byte(8'hFF);
    wait_drain();
    chk("total_wrap", {20'b0, total}, 0);

    // Clear coinciding with a capture keeps that capture's weight.
    push_byte(8'hFF);
    n = 0;
    @(negedge clk);
    while (!(cnt_done && cnt_enable) && n < 100) begin n++; @(negedge clk); end
    chk("clr_cap_seen", {31'b0, cnt_done & cnt_enable}, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_total = 12'd8;
    wait_drain();
    chk("clr_cap_total", {20'b0, total}, {20'b0, exp_total});

    // Reset mid-RUN with three bytes queued.
    push_byte(8'hFF); push_byte(8'h11); push_byte(8'h22); push_byte(8'h44);
    n = 0;
    while (!cnt_enable && n < 50) begin n++; @(posedge clk); #1; end
    chk("rst_run_seen", {31'b0, cnt_enable}, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    exp_total = 12'h000;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_valid", {31'b0, out_valid}, 0);
    chk("post_rst_busy", {31'b0, busy}, 0);
    push_byte(8'h0F);
    wait_drain();
    chk("post_rst_total", {20'b0, total}, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
